// File: rtl/mant_div_24x24_if.sv
// mant_div_24x24_if: operand and result handshake bundle for the mantissa divider
interface mant_div_24x24_if #(parameter int WIDTH = 24);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   q;
  logic             sticky;
  logic             dbz;
  logic             ovf;
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, sticky, dbz, ovf
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, sticky, dbz, ovf
  );
endinterface

// File: rtl/mant_div_24x24.sv
// mant_div_24x24: restoring divider, q = floor({a,0}/b) one bit per cycle with sticky, dbz and ovf
module mant_div_24x24 #(
  parameter int WIDTH = 24
) (
  input logic             clk,
  input logic             rst_n,
  mant_div_24x24_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state, state_nxt;
  logic [WIDTH:0]   r, rn, q_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;
  logic             sticky_r, dbz_r, ovf_r, out_valid_r;
  logic             zero_div, big, ge;
  assign zero_div = bus.b == '0;
  assign big      = {1'b0, bus.a} >= {bus.b, 1'b0};
  assign ge       = r >= {1'b0, b_r};
  assign rn       = ge ? r - {1'b0, b_r} : r;
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.sticky    = sticky_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovf       = ovf_r;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  // next state: exceptional operands skip the iteration and finish in one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (zero_div || big) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // datapath: operand latch, shift-subtract step, result hold and release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      b_r         <= '0;
      cnt         <= '0;
      q_r         <= '0;
      sticky_r    <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          b_r         <= bus.b;
          r           <= {1'b0, bus.a};
          cnt         <= CW'(WIDTH + 1);
          q_r         <= (zero_div || big) ? '1 : '0;
          sticky_r    <= 1'b0;
          dbz_r       <= zero_div;
          ovf_r       <= !zero_div && big;
          out_valid_r <= zero_div || big;
        end
        CALC: begin
          q_r <= {q_r[WIDTH-1:0], ge};
          r   <= rn << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            sticky_r    <= rn != '0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          dbz_r       <= 1'b0;
          ovf_r       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
